m_seq_check: RTL
================

# m_seq_check

Recovers and verifies M-sequence (PRBS) data using the mid-bit recovered clock produced by the M-sequence clock-sync stage. It sits directly downstream of the clock-sync block in the 200 MHz `clk` domain. It samples the raw `sig_in` stream at the falling edge of the recovered clock and self-synchronises a local LFSR. It then reports lock, per-bit errors, the sequence-period marker and an accumulated error count to the display/measurement logic.

## Interface
- `N`, 7: LFSR length; the sequence period is 2^N−1 bits.
- `TAPS`, 7'h60: feedback tap mask. Bit i set means lfsr[i] feeds the XOR. Default is x^7+x^6+1.
- `LOCK_N`, 32: consecutive correct predictions required to declare lock.
- `WIN`, 64: length of the loss-of-lock error window, in bits.
- `LOSS_N`, 8: error count within one window that forces unlock.
- `clk`  in  1  system clock, 200 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  raw M-sequence data, asynchronous to `clk`.
- `sync_clk`  in  1  recovered bit clock from the sync stage, generated in the `clk` domain. It rises at data edges and falls at mid-bit.
- `bit_out`  out  1  sampled data bit.
- `bit_valid`  out  1  one-cycle pulse; `bit_out` is new on this cycle.
- `lock`  out  1  sequence locked.
- `err_pulse`  out  1  one-cycle pulse on a mispredicted bit while in CHECK or LOCKED.
- `seq_start`  out  1  one-cycle pulse on the first bit of each period. Asserted only while locked.
- `err_cnt`  out  16  saturating total of errors counted while locked.

## Operation
- `sig_in` passes through a 2-flop synchroniser, giving `sig_s`. `sync_clk` is registered once, giving `sck_r`.
- Sample event: `sck_r==1 && sync_clk==0`. On this event, `bit_out<=sig_s` and `bit_valid` pulses on the next cycle.
- Prediction: `pred = ^(lfsr & TAPS)`. Shift rule: `lfsr <= {lfsr[N-2:0], b}`.
- States (2-bit):
  - **SEARCH (0):**
    - Shift each received bit into `lfsr` and increment `ld_cnt`.
    - When `ld_cnt` reaches N: if `lfsr` is nonzero, go to CHECK; if `lfsr` is all-zero, clear `ld_cnt` and stay in SEARCH.
  - **CHECK (1):**
    - Each bit: compare the received bit with `pred`, then shift `pred` (not the received bit) into `lfsr`.
    - On a match, increment `match_cnt`.
    - On a mismatch, pulse `err_pulse`, clear `match_cnt` and `ld_cnt`, and go to SEARCH.
    - When `match_cnt` reaches LOCK_N, go to LOCKED and set `lock=1`.
  - **LOCKED (2):**
    - The LFSR free-runs on `pred`.
    - On a mismatch, pulse `err_pulse`, increment `win_err`, and increment `err_cnt` (saturating at 16'hFFFF).
    - `win_bit` counts 0..WIN−1. On its wrap, if `win_err >= LOSS_N`, go to SEARCH and set `lock=0`. In all cases clear `win_err` on the wrap.
    - `win_err` also reaching LOSS_N mid-window forces SEARCH immediately.
  - **State 3:** unreachable; decodes to SEARCH.
- `seq_start` pulses in LOCKED when the post-shift `lfsr` equals all-ones.
- Entering SEARCH from any state clears `ld_cnt`, `match_cnt`, `win_bit` and `win_err`. `err_cnt` is not cleared; only reset clears it.

## Timing
- Reset value of every output is 0. All internal registers reset to 0.
- Latency from a `sync_clk` falling edge at `clk` edge t:
  - `bit_out` and `bit_valid` are valid at t+1.
  - `err_pulse`, `seq_start` and any `lock` change occur in the same cycle as that `bit_valid`.
- `sig_in` to sample point: 2 synchroniser cycles plus the falling-edge detection. The sync stage's half-period margin covers this.
- Minimum spacing between `bit_valid` pulses equals the recovered bit period. No back-pressure.
- Error on the last bit of a window: it counts toward that window before the wrap evaluation.
- `sync_clk` stuck high or low: no samples occur and all state is held.
- `rst_n` asserted mid-lock: immediate asynchronous clear. After release the block starts in SEARCH.
- Lock acquisition is N+LOCK_N error-free bits after the start of SEARCH (39 bits at defaults).

## Configuration
- `M_CHECK_ERRCNT_EN` defined: the 16-bit saturating `err_cnt` accumulator is built.
- `M_CHECK_ERRCNT_EN` undefined: `err_cnt` is tied to 16'd0 and no accumulator is built. `err_pulse`, windowing and lock behaviour are unchanged.

## Test plan
- **Clean lock:** clean PRBS7 (x^7+x^6+1) at 1 Mb/s with an ideal `sync_clk` falling at mid-bit → `lock` rises on the 39th `bit_valid`, `err_pulse` never fires, and `seq_start` pulses every 127 bits.
- **Single error:** after lock, invert one bit → one `err_pulse`, `err_cnt=1`, `lock` stays 1 and `seq_start` spacing is unchanged.
- **Error burst:** after lock, invert 8 bits within one 64-bit window → `lock` drops on the 8th error. With clean data resumed, `lock` returns after 39 bits and `err_cnt=8`.
- **All-zero input:** constant `sig_in=0` → `lock` stays 0 indefinitely and the state stays SEARCH.
- **Reset mid-lock:** pulse `rst_n` low for 3 cycles while locked → all outputs are 0 within the same cycle. After release, relock in 39 bits and `err_cnt` restarts from 0.
- **Macro off:** build without `M_CHECK_ERRCNT_EN` and rerun the single-error scenario → `err_pulse` fires once and `err_cnt` stays 0.

Source files
------------

// File: rtl/m_seq_check.sv
// M-sequence (PRBS) checker: samples sig_in on the recovered clock's falling edge,
// self-synchronises a local LFSR and reports lock/errors. Macro M_CHECK_ERRCNT_EN builds err_cnt.
`timescale 1ns/1ps
module m_seq_check #(
  parameter int unsigned    N      = 7,
  parameter logic [N-1:0]   TAPS   = 7'h60,
  parameter int unsigned    LOCK_N = 32,
  parameter int unsigned    WIN    = 64,
  parameter int unsigned    LOSS_N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        sync_clk,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        lock,
  output logic        err_pulse,
  output logic        seq_start,
  output logic [15:0] err_cnt
);

  localparam int unsigned LDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MW  = $clog2(LOCK_N + 1);
  localparam int unsigned WBW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned EW  = $clog2(LOSS_N + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sig_m, sig_s, sck_r;
  logic [N-1:0]     lfsr_q, lfsr_d;
  logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [WBW-1:0]   win_bit_q, win_bit_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic             bit_out_d, err_d, seq_d;

  logic             sample_c, pred_c, mism_c;
  logic [N-1:0]     shift_c;
  logic [EW-1:0]    win_err_n_c;

  assign sample_c    = sck_r & ~sync_clk;
  assign pred_c      = ^(lfsr_q & TAPS);
  assign mism_c      = sig_s ^ pred_c;
  assign shift_c     = {lfsr_q[N-2:0], pred_c};
  assign win_err_n_c = win_err_q + EW'(mism_c);

`ifdef M_CHECK_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

  // Next-state and datapath update, evaluated only on a sample event
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    ld_cnt_d    = ld_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    bit_out_d   = bit_out;
    err_d       = 1'b0;
    seq_d       = 1'b0;
`ifdef M_CHECK_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    if (sample_c) begin
      bit_out_d = sig_s;
      case (state_q)
        CHECK: begin
          lfsr_d = shift_c;
          if (mism_c) begin
            err_d   = 1'b1;
            state_d = SEARCH;
          end else if (match_cnt_q == MW'(LOCK_N - 1)) begin
            match_cnt_d = MW'(LOCK_N);
            state_d     = LOCKED;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          lfsr_d = shift_c;
          seq_d  = (shift_c == '1);
          err_d  = mism_c;
`ifdef M_CHECK_ERRCNT_EN
          if (mism_c && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
`endif
          // Current bit's error counts before the window-wrap decision
          if (win_err_n_c >= EW'(LOSS_N)) begin
            state_d = SEARCH;
          end else if (win_bit_q == WBW'(WIN - 1)) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + 1'b1;
            win_err_d = win_err_n_c;
          end
        end
        default: begin
          state_d = SEARCH;
          lfsr_d  = {lfsr_q[N-2:0], sig_s};
          if (ld_cnt_q == LDW'(N - 1)) begin
            ld_cnt_d = '0;
            if (lfsr_d != '0) state_d = CHECK;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      endcase
      if ((state_d == SEARCH) && (state_q != SEARCH)) begin
        ld_cnt_d    = '0;
        match_cnt_d = '0;
        win_bit_d   = '0;
        win_err_d   = '0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // Synchronisers, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_m       <= 1'b0;
      sig_s       <= 1'b0;
      sck_r       <= 1'b0;
      lfsr_q      <= '0;
      ld_cnt_q    <= '0;
      match_cnt_q <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      lock        <= 1'b0;
      err_pulse   <= 1'b0;
      seq_start   <= 1'b0;
`ifdef M_CHECK_ERRCNT_EN
      err_cnt_q   <= 16'd0;
`endif
    end else begin
      sig_m       <= sig_in;
      sig_s       <= sig_m;
      sck_r       <= sync_clk;
      lfsr_q      <= lfsr_d;
      ld_cnt_q    <= ld_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      bit_out     <= bit_out_d;
      bit_valid   <= sample_c;
      lock        <= (state_d == LOCKED);
      err_pulse   <= err_d;
      seq_start   <= seq_d;
`ifdef M_CHECK_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule
